jtframe_rom_arb: RTL and testbench

//  Parametrised SDRAM ROM-slot arbiter: successor to the fixed 9-slot ROM controller used by game tops.

---
 rtl/jtframe_rom_arb_pkg.sv | 34 +++
 rtl/jtframe_rom_arb_slot.sv | 68 ++++++
 rtl/jtframe_rom_arb.sv | 180 ++++++++++++++++++
 tb/tb_jtframe_rom_arb.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_rom_arb_pkg.sv
// Shared types and SDRAM word-address mapping for the ROM-slot arbiter.
package jtframe_rom_arb_pkg;

    localparam int unsigned SDRAM_AW   = 22;
    // One extra bit so 8-bit slots can still reach the full word range after the shift.
    localparam int unsigned ADDR_EXT_W = SDRAM_AW + 1;

    typedef enum logic [1:0] {
        DW8  = 2'd0,
        DW16 = 2'd1,
        DW32 = 2'd2
    } dw_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    function automatic logic [SDRAM_AW-1:0] map_word(
        input logic [ADDR_EXT_W-1:0] addr,
        input logic [1:0]            dw_sel,
        input logic [SDRAM_AW-1:0]   offset
    );
        logic [SDRAM_AW-1:0] rel;
        case (dw_e'(dw_sel))
            DW8:     rel = addr[SDRAM_AW:1];
            DW32:    rel = {addr[SDRAM_AW-2:0], 1'b0};
            default: rel = addr[SDRAM_AW-1:0];
        endcase
        return offset + rel;
    endfunction

endpackage

// File: rtl/jtframe_rom_arb_slot.sv
// One ROM slot: single-word cache, hit compare, address map and output data select.
module jtframe_rom_arb_slot
    import jtframe_rom_arb_pkg::*;
#(
    parameter int unsigned         AW     = 18,
    parameter logic [1:0]          DW_SEL = 2'd1,
    parameter logic [SDRAM_AW-1:0] OFFSET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                en,
    input  logic                cs,
    input  logic [AW-1:0]       addr,
    input  logic                wr,
    input  logic [31:0]         wr_data,
    input  logic [SDRAM_AW-1:0] wr_tag,
    output logic [SDRAM_AW-1:0] word,
    output logic                miss,
    output logic                ok,
    output logic [31:0]         dout
);

    logic [31:0]         data_q;
    logic [SDRAM_AW-1:0] tag_q;
    logic                valid_q;
    logic [31:0]         dout_q;
    logic [31:0]         sel;
    logic                hit;

    assign word = map_word(ADDR_EXT_W'(addr), DW_SEL, OFFSET);
    assign hit  = valid_q && (tag_q == word);
    assign ok   = en && cs && hit;
    assign miss = en && cs && !hit;

    // 8-bit slots share one 16-bit SDRAM word between two byte addresses.
    always_comb begin
        sel = '0;
        case (dw_e'(DW_SEL))
            DW8:     sel = {24'd0, addr[0] ? data_q[15:8] : data_q[7:0]};
            DW32:    sel = data_q;
            default: sel = {16'd0, data_q[15:0]};
        endcase
    end

    assign dout = ok ? sel : dout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            dout_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (wr) begin
                valid_q <= 1'b1;
                data_q  <= wr_data;
                tag_q   <= wr_tag;
            end
            if (ok) begin
                dout_q <= sel;
            end
        end
    end

endmodule

// File: rtl/jtframe_rom_arb.sv
// SDRAM ROM-slot arbiter: per-slot word caches, one shared read port, FP or RR arbitration.
// Define JTFRAME_ROMARB_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module jtframe_rom_arb
    import jtframe_rom_arb_pkg::*;
#(
    parameter int unsigned                SLOTS   = 4,
    parameter int unsigned                AW      = 18,
    parameter logic [2*SLOTS-1:0]         DW_SEL  = {SLOTS{2'd1}},
    parameter logic [SDRAM_AW*SLOTS-1:0]  OFFSETS = '0,
    parameter int unsigned                RR_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*32-1:0]   slot_dout,
    input  logic                  downloading,
    input  logic                  loop_rst,
    output logic                  sdram_req,
    output logic [SDRAM_AW-1:0]   sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [31:0]           data_read,
    output logic                  refresh_en
`ifdef JTFRAME_ROMARB_STATS_EN
    ,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);

    localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [SDRAM_AW-1:0] addr_q, addr_d;
    logic [IW-1:0]       win_q, win_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       pick;
    logic                found;
    int unsigned         scan;
    logic                halt;
    logic                en;
    logic                wr;
    logic [SLOTS-1:0]    pend;
    logic [SDRAM_AW-1:0] words [SLOTS];

    assign halt = downloading || loop_rst;
    assign en   = rst_n && !halt;

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        jtframe_rom_arb_slot #(
            .AW     (AW),
            .DW_SEL (DW_SEL[2*s +: 2]),
            .OFFSET (OFFSETS[SDRAM_AW*s +: SDRAM_AW])
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (halt),
            .en      (en),
            .cs      (slot_cs[s]),
            .addr    (slot_addr[AW*s +: AW]),
            .wr      (wr && (win_q == IW'(s))),
            .wr_data (data_read),
            .wr_tag  (addr_q),
            .word    (words[s]),
            .miss    (pend[s]),
            .ok      (slot_ok[s]),
            .dout    (slot_dout[32*s +: 32])
        );
    end

    // Scan starts at the RR pointer (or at 0) and wraps; first pending slot wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        scan  = 0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            scan = (RR_MODE != 0) ? 32'(rr_q) + k : k;
            if (scan >= SLOTS) begin
                scan = scan - SLOTS;
            end
            if (!found && pend[IW'(scan)]) begin
                found = 1'b1;
                pick  = IW'(scan);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        win_d   = win_q;
        rr_d    = rr_q;
        wr      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    addr_d  = words[pick];
                    win_d   = pick;
                    if (RR_MODE != 0) begin
                        rr_d = (32'(pick) == SLOTS - 1) ? '0 : pick + 1'b1;
                    end
                end
            end
            StReq: begin
                if (sdram_ack) begin
                    req_d = 1'b0;
                    // Controllers with zero read latency may return data with the ack.
                    if (data_rdy) begin
                        wr      = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (data_rdy) begin
                    wr      = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
        if (halt) begin
            state_d = StIdle;
            req_d   = 1'b0;
            wr      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= '0;
            win_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
        end
    end

    assign sdram_req  = req_q && en;
    assign sdram_addr = addr_q;
    assign refresh_en = (state_q == StIdle) && !found;

`ifdef JTFRAME_ROMARB_STATS_EN
    logic launch;

    assign launch = (state_q == StIdle) && found && en;

    always_ff @(posedge clk) begin
        if (!rst_n || downloading) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (|slot_ok && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (launch && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Bench for jtframe_rom_arb: transaction-level cache model checked every cycle plus directed cases.
module tb_jtframe_rom_arb;

    localparam int AW = 18;
    localparam logic [7:0]  DWS  = {2'd1, 2'd2, 2'd1, 2'd0};
    localparam logic [87:0] OFFS = {22'h3000, 22'h2000, 22'h1000, 22'h0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   slot_cs;
    logic [71:0]  slot_addr;
    logic [3:0]   slot_ok;
    logic [127:0] slot_dout;
    logic         downloading, loop_rst;
    logic         sdram_req;
    logic [21:0]  sdram_addr;
    logic         sdram_ack, data_rdy;
    logic [31:0]  data_read;
    logic         refresh_en;

    logic [3:0]   fp_ok;
    logic [127:0] fp_dout;
    logic         fp_req, fp_ack, fp_refresh;
    logic [21:0]  fp_addr;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    jtframe_rom_arb #(
        .SLOTS(4), .AW(AW), .DW_SEL(DWS), .OFFSETS(OFFS), .RR_MODE(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_ok(slot_ok), .slot_dout(slot_dout), .downloading(downloading),
        .loop_rst(loop_rst), .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
        .refresh_en(refresh_en)
    );

    // Fixed-priority twin with an instant controller (ack and data together).
    assign fp_ack = fp_req;
    jtframe_rom_arb #(
        .SLOTS(4), .AW(AW), .DW_SEL(DWS), .OFFSETS(OFFS), .RR_MODE(0)
    ) u_fp (
        .clk(clk), .rst_n(rst_n), .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_ok(fp_ok), .slot_dout(fp_dout), .downloading(downloading),
        .loop_rst(loop_rst), .sdram_req(fp_req), .sdram_addr(fp_addr),
        .sdram_ack(fp_ack), .data_rdy(fp_ack), .data_read(32'h0),
        .refresh_en(fp_refresh)
    );

    // ---------------- behavioural model of u_dut ----------------
    int          m_off [4] = '{0, 'h1000, 'h2000, 'h3000};
    int          m_dw  [4] = '{8, 16, 32, 16};
    bit          m_valid [4];
    bit [21:0]   m_tag [4];
    bit [31:0]   m_data [4];
    bit [31:0]   m_hold [4];
    bit          m_busy;      // a request is outstanding
    bit          m_acked;     // controller has accepted it
    bit [21:0]   m_addr;
    int          m_win;
    int          m_rr;

    function automatic bit [17:0] addr_of(int s);
        return slot_addr[s*AW +: AW];
    endfunction

    function automatic bit [21:0] m_word(int s, bit [17:0] a);
        int unsigned w;
        if (m_dw[s] == 8)       w = 32'(m_off[s]) + 32'(a) / 2;
        else if (m_dw[s] == 32) w = 32'(m_off[s]) + 32'(a) * 2;
        else                    w = 32'(m_off[s]) + 32'(a);
        return 22'(w);
    endfunction

    function automatic bit m_halt();
        return !rst_n || downloading || loop_rst;
    endfunction

    function automatic bit m_hit(int s);
        return m_valid[s] && (m_tag[s] == m_word(s, addr_of(s)));
    endfunction

    function automatic bit m_ok(int s);
        return slot_cs[s] && !m_halt() && m_hit(s);
    endfunction

    function automatic bit m_pend(int s);
        return slot_cs[s] && !m_halt() && !m_hit(s);
    endfunction

    function automatic bit [31:0] m_sel(int s);
        bit [17:0] a;
        a = addr_of(s);
        if (m_dw[s] == 8)  return (a % 2 == 1) ? {24'd0, m_data[s][15:8]} : {24'd0, m_data[s][7:0]};
        if (m_dw[s] == 16) return {16'd0, m_data[s][15:0]};
        return m_data[s];
    endfunction

    function automatic bit [31:0] m_dout(int s);
        return m_ok(s) ? m_sel(s) : m_hold[s];
    endfunction

    task automatic m_fill(int s);
        m_valid[s] = 1;
        m_tag[s]   = m_addr;
        m_data[s]  = data_read;
    endtask

    task automatic model_step();
        int w;
        int s;
        for (int i = 0; i < 4; i++) if (m_ok(i)) m_hold[i] = m_sel(i);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] = 0;
                m_hold[i]  = 0;
            end
            m_busy = 0; m_acked = 0; m_addr = 0; m_win = 0; m_rr = 0;
        end else if (downloading || loop_rst) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 0;
            m_busy = 0; m_acked = 0;
        end else if (!m_busy) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                s = (m_rr + k) % 4;
                if (w < 0 && m_pend(s)) w = s;
            end
            if (w >= 0) begin
                m_busy = 1; m_acked = 0; m_win = w;
                m_addr = m_word(w, addr_of(w));
                m_rr   = (w + 1) % 4;
            end
        end else if (!m_acked) begin
            if (sdram_ack) begin
                if (data_rdy) begin
                    m_fill(m_win);
                    m_busy = 0;
                end else begin
                    m_acked = 1;
                end
            end
        end else if (data_rdy) begin
            m_fill(m_win);
            m_busy = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit any_pend;
        any_pend = 0;
        for (int s = 0; s < 4; s++) any_pend |= m_pend(s);
        chk("cyc_req", 32'(sdram_req), 32'(m_busy && !m_acked && !m_halt()));
        chk("cyc_addr", 32'(sdram_addr), 32'(m_addr));
        chk("cyc_refresh", 32'(refresh_en), 32'(!m_busy && !any_pend));
        for (int s = 0; s < 4; s++) begin
            chk("cyc_ok", 32'(slot_ok[s]), 32'(m_ok(s)));
            chk("cyc_dout", slot_dout[s*32 +: 32], m_dout(s));
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int s, input logic [17:0] a);
        slot_addr[s*AW +: AW] = a;
    endtask

    task automatic serve(input int ack_dly, input int rdy_dly, input logic [31:0] d,
                         output logic [21:0] a);
        int n;
        n = 0;
        while (!sdram_req && n < 50) begin
            tick();
            n++;
        end
        chk("serve_req_seen", 32'(sdram_req), 32'd1);
        a = sdram_addr;
        repeat (ack_dly) tick();
        sdram_ack = 1;
        if (rdy_dly == 0) begin
            data_rdy  = 1;
            data_read = d;
        end
        tick();
        sdram_ack = 0;
        data_rdy  = 0;
        if (rdy_dly > 0) begin
            repeat (rdy_dly - 1) tick();
            data_rdy  = 1;
            data_read = d;
            tick();
            data_rdy  = 0;
        end
    endtask

    logic [21:0] ga, gb;
    int          grant [5];
    int          exp_order [5] = '{0, 1, 2, 3, 0};
    int          fp_g0, fp_g3, n;

    initial begin
        rst_n = 0; slot_cs = 4'hF; slot_addr = '0; downloading = 0; loop_rst = 0;
        sdram_ack = 0; data_rdy = 0; data_read = '0;

        // Reset with every slot requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_en = 1;
            chk("rst_req", 32'(sdram_req), 32'd0);
            chk("rst_ok", 32'(slot_ok), 32'd0);
            chk("rst_refresh", 32'(refresh_en), 32'd1);
        end
        slot_cs = 0; rst_n = 1;
        tick();

        // 16-bit miss then hit
        set_addr(1, 18'd5); slot_cs = 4'b0010;
        serve(2, 1, 32'hBEEF_1234, ga);
        chk("t2_addr", 32'(ga), 32'h1005);
        chk("t2_ok", 32'(slot_ok[1]), 32'd1);
        chk("t2_dout", slot_dout[63:32], 32'h0000_1234);
        slot_cs = 0;
        tick();
        slot_cs = 4'b0010;
        #1;
        chk("t2_rehit", 32'(slot_ok[1]), 32'd1);
        repeat (3) begin
            tick();
            chk("t2_no_req", 32'(sdram_req), 32'd0);
        end

        // 8-bit byte select
        set_addr(0, 18'd7); slot_cs = 4'b0001;
        serve(1, 1, 32'h0000_A55A, ga);
        chk("t3_addr", 32'(ga), 32'h3);
        chk("t3_hi_byte", slot_dout[31:0], 32'h0000_00A5);
        set_addr(0, 18'd6);
        #1;
        chk("t3_lo_ok", 32'(slot_ok[0]), 32'd1);
        chk("t3_lo_byte", slot_dout[31:0], 32'h0000_005A);
        tick();
        chk("t3_no_req", 32'(sdram_req), 32'd0);

        // Round-robin with every slot re-missing
        rst_n = 0; slot_cs = 0;
        tick();
        rst_n = 1;
        set_addr(0, 18'h10); set_addr(1, 18'h20); set_addr(2, 18'h30); set_addr(3, 18'h40);
        slot_cs = 4'hF;
        for (int i = 0; i < 5; i++) begin
            serve(1, 1, 32'h1000_0000 + 32'(i), ga);
            grant[i] = int'(ga[13:12]);
            slot_addr[grant[i]*AW +: AW] = slot_addr[grant[i]*AW +: AW] + 18'd2;
            chk("t4_grant", 32'(grant[i]), 32'(exp_order[i]));
        end

        // Fixed priority: slot0 misses every access, slot3 starves
        fp_g0 = 0; fp_g3 = 0;
        set_addr(3, 18'h77); slot_cs = 4'b1001;
        for (int i = 0; i < 20; i++) begin
            set_addr(0, 18'(200 + 2 * i));
            tick();
            if (fp_req && fp_addr[13:12] == 2'd0) fp_g0++;
            if (fp_req && fp_addr[13:12] == 2'd3) fp_g3++;
        end
        chk("fp_slot3_grants", 32'(fp_g3), 32'd0);
        chk("fp_slot0_busy", 32'(fp_g0 >= 8), 32'd1);
        slot_cs = 4'b1000;
        n = 0;
        while (!fp_ok[3] && n < 10) begin
            tick();
            n++;
        end
        chk("fp_slot3_served", 32'(fp_ok[3]), 32'd1);

        // Download in the middle of a read
        downloading = 1; slot_cs = 0;
        tick();
        downloading = 0;
        set_addr(3, 18'h50); slot_cs = 4'b1000;
        serve(1, 1, 32'h0000_5150, ga);
        chk("t5_pre_ok", 32'(slot_ok[3]), 32'd1);
        set_addr(2, 18'h20); slot_cs = 4'b1100;
        tick();
        chk("t5_launch", 32'(sdram_req), 32'd1);
        chk("t5_launch_addr", 32'(sdram_addr), 32'h2040);
        sdram_ack = 1;
        tick();
        sdram_ack = 0;
        tick();
        downloading = 1;
        #1;
        chk("t5_dl_req", 32'(sdram_req), 32'd0);
        chk("t5_dl_ok", 32'(slot_ok), 32'd0);
        tick();
        data_rdy = 1; data_read = 32'hDEAD_0BAD;
        tick();
        data_rdy = 0;
        chk("t5_late_rdy_ok", 32'(slot_ok), 32'd0);
        downloading = 0; data_rdy = 1;
        tick();
        data_rdy = 0;
        chk("t5_refetch", 32'(sdram_req), 32'd1);
        chk("t5_stray_ok", 32'(slot_ok[2]), 32'd0);
        serve(1, 1, 32'h0000_7777, ga);
        serve(1, 1, 32'h0000_7777, gb);
        chk("t5_first", 32'(ga), 32'h3050);
        chk("t5_second", 32'(gb), 32'h2040);
        chk("t5_ok", 32'(slot_ok), 32'hC);
        chk("t5_dout", slot_dout[95:64], 32'h0000_7777);

        // Ack and data in the same cycle
        slot_cs = 4'b1000; set_addr(3, 18'd9);
        serve(0, 0, 32'hCAFE_F00D, ga);
        chk("t6_addr", 32'(ga), 32'h3009);
        chk("t6_ok", 32'(slot_ok[3]), 32'd1);
        chk("t6_dout", slot_dout[127:96], 32'h0000_F00D);
        chk("t6_idle", 32'(refresh_en), 32'd1);

        // Soft reset behaves like a download
        loop_rst = 1;
        #1;
        chk("lr_ok", 32'(slot_ok[3]), 32'd0);
        tick();
        loop_rst = 0;
        tick();
        chk("lr_refetch", 32'(sdram_req), 32'd1);
        chk("lr_addr", 32'(sdram_addr), 32'h3009);
        serve(1, 1, 32'h0000_ABCD, ga);
        chk("lr_dout", slot_dout[127:96], 32'h0000_ABCD);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
